vga_timing_gen: RTL

//  Source end of the pixel-coordinate interface: generates H_cont/V_cont, which

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 17 +
 rtl/vga_axis_counter.sv | 83 ++++++++
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA pixel path.
// Contents:
//   VGA_640X480_*  default 640x480@60 timing (pixels / lines)
//   coord_t        signed 13-bit screen coordinate
//   seg_t          position of a counter within a line or frame
//   sync_t         undelayed sync/visible flags carried down the delay line
package vga_pkg;

  localparam int VGA_640X480_H_ACTIVE = 640;
  localparam int VGA_640X480_H_FP     = 16;
  localparam int VGA_640X480_H_SYNC   = 96;
  localparam int VGA_640X480_H_BP     = 48;
  localparam int VGA_640X480_V_ACTIVE = 480;
  localparam int VGA_640X480_V_FP     = 10;
  localparam int VGA_640X480_V_SYNC   = 2;
  localparam int VGA_640X480_V_BP     = 33;

  typedef logic signed [12:0] coord_t;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } seg_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_t;

  // Idle value of the delay line: no sync pulse, not visible.
  localparam sync_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, vis: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bus between the timing generator and the overlay chain.
//   H_cont, V_cont       signed coordinates from the generator
//   iRed, iGreen, iBlue  registered colour returned by the overlays
// master: timing generator side, slave: overlay side.
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t     H_cont;
  coord_t     V_cont;
  logic [7:0] iRed;
  logic [7:0] iGreen;
  logic [7:0] iBlue;

  modport master (output H_cont, output V_cont, input iRed, input iGreen, input iBlue);
  modport slave  (input H_cont, input V_cont, output iRed, output iGreen, output iBlue);

endinterface

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA raster.
//   clk, reset  clock, asynchronous active-high reset
//   ce          advance one position
//   wrap_out    high while ce is high on the last position of the axis
//   raw         unsigned position 0..TOT-1, sync pulse starts at 0
//   seg         SYNC / BACK / ACTIVE / FRONT segment of the current position
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  output logic           wrap_out,
  output logic [11:0]    raw,
  output vga_pkg::seg_t  seg
);

  localparam int TOT = ACTIVE + FP + SYNC + BP;
  localparam logic [11:0] LAST     = 12'(TOT - 1);
  localparam logic [11:0] SYNC_END = 12'(SYNC - 1);
  localparam logic [11:0] BACK_END = 12'(SYNC + BP - 1);
  localparam logic [11:0] ACT_END  = 12'(SYNC + BP + ACTIVE - 1);

  // The segment FSM needs every segment to be at least one position long.
  if (TOT >= 4096) begin : g_bad_tot
    $error("vga_axis_counter: total of %0d does not fit a 12-bit counter", TOT);
  end
  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_seg
    $error("vga_axis_counter: every segment length must be at least 1");
  end

  logic [11:0]   raw_r;
  logic          at_last_s;
  vga_pkg::seg_t seg_r;
  vga_pkg::seg_t seg_nxt_s;

  assign at_last_s = (raw_r == LAST);
  assign wrap_out  = ce & at_last_s;
  assign raw       = raw_r;

  // Raw position counter, wraps to the start of the sync pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_r <= 12'd0;
    end else if (ce) begin
      if (at_last_s) begin
        raw_r <= 12'd0;
      end else begin
        raw_r <= raw_r + 12'd1;
      end
    end
  end

  // Segment state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r <= vga_pkg::SYNC;
    end else if (ce) begin
      seg_r <= seg_nxt_s;
    end
  end

  // Segment next state: leave a segment on its last position.
  always_comb begin
    seg_nxt_s = seg_r;
    case (seg_r)
      vga_pkg::SYNC:   seg_nxt_s = (raw_r == SYNC_END) ? vga_pkg::BACK   : vga_pkg::SYNC;
      vga_pkg::BACK:   seg_nxt_s = (raw_r == BACK_END) ? vga_pkg::ACTIVE : vga_pkg::BACK;
      vga_pkg::ACTIVE: seg_nxt_s = (raw_r == ACT_END)  ? vga_pkg::FRONT  : vga_pkg::ACTIVE;
      vga_pkg::FRONT:  seg_nxt_s = at_last_s           ? vga_pkg::SYNC   : vga_pkg::FRONT;
      default:         seg_nxt_s = vga_pkg::SYNC;
    endcase
  end

  // Segment output decode (Moore: the state is the output).
  always_comb begin
    seg = seg_r;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source and DAC output stage.
//   clk, reset         clock, asynchronous active-high reset
//   pix_ce             pixel tick; everything except frame_start holds when low
//   pix (master)       H_cont/V_cont out, iRed/iGreen/iBlue back from the
//                      overlays PIPE_DLY ticks later
//   oVGA_HS, oVGA_VS   active-low syncs, realigned with the returned colour
//   oVGA_BLANK_N       high on visible pixels
//   oVGA_SYNC_N        tied low
//   oVGA_R/G/B         colour to the DAC, zero while blanked
//   frame_start        one-clk pulse as the raster returns to its origin
//   frame_count        frames completed since reset (wraps)
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_640X480_H_ACTIVE,
  parameter int H_FP     = VGA_640X480_H_FP,
  parameter int H_SYNC   = VGA_640X480_H_SYNC,
  parameter int H_BP     = VGA_640X480_H_BP,
  parameter int V_ACTIVE = VGA_640X480_V_ACTIVE,
  parameter int V_FP     = VGA_640X480_V_FP,
  parameter int V_SYNC   = VGA_640X480_V_SYNC,
  parameter int V_BP     = VGA_640X480_V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  vga_timing_gen_if.master  pix,
  output logic              oVGA_HS,
  output logic              oVGA_VS,
  output logic              oVGA_BLANK_N,
  output logic              oVGA_SYNC_N,
  output logic [7:0]        oVGA_R,
  output logic [7:0]        oVGA_G,
  output logic [7:0]        oVGA_B,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  localparam coord_t HB = coord_t'(H_SYNC + H_BP);
  localparam coord_t VB = coord_t'(V_SYNC + V_BP);

  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY %0d outside 1..4", PIPE_DLY);
  end

  logic        h_wrap_s;
  logic        v_wrap_s;
  logic [11:0] raw_h_s;
  logic [11:0] raw_v_s;
  seg_t        h_seg_s;
  seg_t        v_seg_s;
  sync_t       stage_in_s;
  sync_t       dly_out_s;
  sync_t       dly_r [PIPE_DLY];
  logic        hs_r;
  logic        vs_r;
  logic        blank_n_r;
  logic [7:0]  red_r;
  logic [7:0]  green_r;
  logic [7:0]  blue_r;
  logic        frame_start_r;
  logic [15:0] frame_count_r;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
  ) u_h_cnt (
    .clk (clk), .reset (reset), .ce (pix_ce),
    .wrap_out (h_wrap_s), .raw (raw_h_s), .seg (h_seg_s)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
  ) u_v_cnt (
    .clk (clk), .reset (reset), .ce (h_wrap_s),
    .wrap_out (v_wrap_s), .raw (raw_v_s), .seg (v_seg_s)
  );

  // Coordinates are shifted so the first visible pixel is (0,0).
  assign pix.H_cont = coord_t'({1'b0, raw_h_s}) - HB;
  assign pix.V_cont = coord_t'({1'b0, raw_v_s}) - VB;

  // Undelayed sync and visibility for the current raster position.
  always_comb begin
    stage_in_s     = SYNC_IDLE;
    stage_in_s.hs  = (raw_h_s < 12'(H_SYNC));
    stage_in_s.vs  = (raw_v_s < 12'(V_SYNC));
    stage_in_s.vis = (h_seg_s == ACTIVE) && (v_seg_s == ACTIVE);
  end

  assign dly_out_s = dly_r[PIPE_DLY-1];

  // Delay line matching the overlay latency, so flags meet their own colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        dly_r[i] <= SYNC_IDLE;
      end
    end else if (pix_ce) begin
      dly_r[0] <= stage_in_s;
      for (int i = 1; i < PIPE_DLY; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  // DAC output stage; colour is forced dark outside the visible window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_n_r <= 1'b0;
      red_r     <= 8'd0;
      green_r   <= 8'd0;
      blue_r    <= 8'd0;
    end else if (pix_ce) begin
      hs_r      <= ~dly_out_s.hs;
      vs_r      <= ~dly_out_s.vs;
      blank_n_r <= dly_out_s.vis;
      red_r     <= dly_out_s.vis ? pix.iRed   : 8'd0;
      green_r   <= dly_out_s.vis ? pix.iGreen : 8'd0;
      blue_r    <= dly_out_s.vis ? pix.iBlue  : 8'd0;
    end
  end

  // Frame marker and counter; v wrap already implies pix_ce and h wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start_r <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      frame_start_r <= v_wrap_s;
      if (v_wrap_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

  assign oVGA_HS      = hs_r;
  assign oVGA_VS      = vs_r;
  assign oVGA_BLANK_N = blank_n_r;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_R       = red_r;
  assign oVGA_G       = green_r;
  assign oVGA_B       = blue_r;
  assign frame_start  = frame_start_r;
  assign frame_count  = frame_count_r;

endmodule
